// File: rtl/alu_seq_if.sv
// Handshake bundle between the decode stage (master) and alu_seq (slave):
// operand/op request channel plus result/flag response channel.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_dbz;

    modport master (
        output in_valid, op, rs, rt, out_ready,
        input  in_ready, out_valid, alu_out, flag_zero, flag_carry, flag_dbz
    );

    modport slave (
        input  in_valid, op, rs, rt, out_ready,
        output in_ready, out_valid, alu_out, flag_zero, flag_carry, flag_dbz
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle add/sub/mul/logic ops and an
// iterative restoring divider for DIV/MOD, with valid/ready on both sides.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic               rdy_q;
    logic [WIDTH-1:0]   alu_q, alu_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mod_q, mod_d;
    logic               load_s;

    logic               in_ready_s;
    logic               accept_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     shift_s;
    logic [WIDTH:0]     trial_s;

    // rdy_q keeps in_ready low while reset is held even though state sits in IDLE
    assign in_ready_s = rdy_q && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_DONE) && bus.out_ready));
    assign accept_s   = bus.in_valid && in_ready_s;

    assign sum_s   = {1'b0, bus.rs} + {1'b0, bus.rt};
    assign diff_s  = {1'b0, bus.rs} - {1'b0, bus.rt};
    assign prod_s  = {{WIDTH{1'b0}}, bus.rs} * {{WIDTH{1'b0}}, bus.rt};
    // Restoring step: bit WIDTH of the trial difference is the "does not fit" indicator
    assign shift_s = {rem_q, quot_q[WIDTH-1]};
    assign trial_s = shift_s - {1'b0, dvs_q};

    // Next-state, result and divider datapath
    always_comb begin
        state_d = state_q;
        alu_d   = alu_q;
        carry_d = carry_q;
        dbz_d   = dbz_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        mod_d   = mod_q;
        load_s  = 1'b0;

        if (accept_s) begin
            state_d = ST_DONE;
            load_s  = 1'b1;
            carry_d = 1'b0;
            dbz_d   = 1'b0;
            case (bus.op)
                OP_ADD: begin
                    alu_d   = sum_s[WIDTH-1:0];
                    carry_d = sum_s[WIDTH];
                end
                OP_SUB: begin
                    alu_d   = diff_s[WIDTH-1:0];
                    carry_d = diff_s[WIDTH];
                end
                OP_MUL: begin
                    alu_d   = prod_s[WIDTH-1:0];
                    carry_d = |prod_s[2*WIDTH-1:WIDTH];
                end
                OP_DIV, OP_MOD: begin
                    if (bus.rt == {WIDTH{1'b0}}) begin
                        alu_d = (bus.op == OP_DIV) ? {WIDTH{1'b1}} : bus.rs;
                        dbz_d = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        load_s  = 1'b0;
                        carry_d = carry_q;
                        dbz_d   = dbz_q;
                        quot_d  = bus.rs;
                        rem_d   = {WIDTH{1'b0}};
                        dvs_d   = bus.rt;
                        cnt_d   = CNT_W'(WIDTH);
                        mod_d   = (bus.op == OP_MOD);
                    end
                end
                OP_AND:  alu_d = bus.rs & bus.rt;
                OP_OR:   alu_d = bus.rs | bus.rt;
                OP_XOR:  alu_d = bus.rs ^ bus.rt;
                default: alu_d = {WIDTH{1'b0}};
            endcase
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_BUSY: begin
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (!trial_s[WIDTH]) begin
                            rem_d  = trial_s[WIDTH-1:0];
                            quot_d = {quot_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_d  = shift_s[WIDTH-1:0];
                            quot_d = {quot_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        state_d = ST_DONE;
                        load_s  = 1'b1;
                        alu_d   = mod_q ? rem_q : quot_q;
                        carry_d = 1'b0;
                        dbz_d   = 1'b0;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (load_s) begin
            zero_d = (alu_d == {WIDTH{1'b0}});
        end else begin
            zero_d = zero_q;
        end
    end

    // State, result and divider registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            alu_q   <= {WIDTH{1'b0}};
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dvs_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            mod_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            alu_q   <= alu_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            mod_q   <= mod_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.alu_out    = alu_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_dbz   = dbz_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the 4-bit single-cycle ALU. Executes ADD/SUB/MUL/DIV/MOD/AND/OR/XOR on WIDTH-bit operands. Single-cycle ops complete in one cycle; DIV/MOD run on an iterative restoring divider. Valid/ready on both sides, so the block sits between the decode stage and the register-file writeback with backpressure.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
CNT_W, $clog2(WIDTH+1), divider iteration counter width (derived, do not override)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept an operation this cycle
op  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101 AND, 110 OR, 111 XOR
rs  in  WIDTH  operand A (unsigned)
rt  in  WIDTH  operand B (unsigned)
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
alu_out  out  WIDTH  result
flag_zero  out  1  alu_out == 0
flag_carry  out  1  ADD carry-out / SUB borrow / MUL high half nonzero; 0 otherwise
flag_dbz  out  1  DIV/MOD with rt == 0

Behaviour:
- Reset (reset low, async, any state): state IDLE; in_ready=0 while reset is asserted, 1 from the first clk after release; out_valid=0; alu_out=0; all flags=0; divider registers cleared. Reset mid-divide abandons the operation; no result is produced.
- FSM states: IDLE, BUSY (divider iterating), DONE (result held).
- in_ready = (state==IDLE) || (state==DONE && out_ready). Accept = in_valid && in_ready. Operands and op are latched on accept; the inputs are don't-care afterwards.
- IDLE or DONE with accept, op in {ADD,SUB,MUL,AND,OR,XOR}: result and flags registered on that edge; next state DONE; out_valid=1 the following cycle (latency 1).
- Accept with op DIV/MOD, rt!=0: next state BUSY; counter loaded with WIDTH. The divider processes one quotient bit per cycle, MSB first. When the counter reaches 0, the result is written and the state moves to DONE. out_valid rises exactly WIDTH+1 cycles after the accept edge.
- Accept with op DIV/MOD, rt==0: no BUSY; DONE next cycle. DIV result = all ones; MOD result = rs; flag_dbz=1; flag_carry=0.
- DONE: out_valid=1; alu_out and flags held stable until out_ready. On out_ready: if a new accept occurs on the same edge, follow the accept rules above (back-to-back, no bubble for 1-cycle ops). Otherwise go to IDLE and drop out_valid.
- DONE without out_ready: in_ready=0, outputs frozen regardless of in_valid.
- BUSY: in_ready=0; out_valid=0; in_valid ignored.
- Arithmetic:
  - ADD: alu_out = low WIDTH bits of rs+rt; carry = bit WIDTH of the sum.
  - SUB: alu_out = rs-rt mod 2^WIDTH; carry = (rs<rt).
  - MUL: alu_out = low WIDTH bits of the 2*WIDTH product; carry = (high half != 0).
  - DIV: quotient. MOD: remainder.
  - Logic ops: carry = 0.
  - flag_zero is computed on the final alu_out for every op, including dbz cases.
- flag_dbz is 0 for every result except DIV/MOD with rt==0.
- Flags and alu_out change only on the edge that raises out_valid (or at reset).

Test Plan:
- Reset then ADD rs=0xF0, rt=0x20 with out_ready=1 -> one cycle later out_valid=1, alu_out=0x10, carry=1, zero=0.
- SUB rs=0x05, rt=0x05 -> alu_out=0x00, zero=1, carry=0. Then SUB rs=0x03, rt=0x05 -> alu_out=0xFE, carry=1.
- MUL rs=0x10, rt=0x10 -> alu_out=0x00, carry=1, zero=1. DIV rs=200, rt=7 -> out_valid exactly 9 cycles after accept, alu_out=28. MOD with the same operands -> 4. in_ready=0 throughout BUSY.
- DIV rs=0x55, rt=0 -> next cycle alu_out=0xFF, flag_dbz=1. MOD rs=0x55, rt=0 -> alu_out=0x55, dbz=1.
- Backpressure: hold out_ready=0 for 5 cycles after an XOR result while in_valid=1 with new operands -> alu_out stable and in_ready=0. Raise out_ready -> new op accepted on that edge and its result appears the next cycle.
- Assert reset low asynchronously mid-DIV (cycle 4 of BUSY) -> out_valid=0 and alu_out=0 immediately. After release, a new ADD 1+1 returns 2 with latency 1.
